ecc_op_sequencer: RTL and testbench

ECC_OP_SEQUENCER -- requirements
Module: ecc_op_sequencer

---
 rtl/ecc_pkg.sv | 28 ++
 rtl/ecc_opd_buf.sv | 35 +++
 rtl/ecc_op_sequencer.sv | 142 ++++++++++++++
 tb/tb_ecc_op_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
// Shared ECC definitions: operation codes, response error codes and sequencer state encoding.
// Used by both the op sequencer and the engine decoder so the encodings cannot drift apart.
package ecc_pkg;

    localparam logic [2:0] OP_RAND = 3'b000;
    localparam logic [2:0] OP_INVS = 3'b001;
    localparam logic [2:0] OP_MMUL = 3'b101;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_GAP   = 3'd3,
        ST_WAIT  = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    // Only these mode/operand-count pairings are understood by the engine.
    function automatic logic cmd_legal(input logic [2:0] mode, input logic [2:0] nops);
        return (((mode == OP_RAND) || (mode == OP_INVS)) && (nops == 3'd0)) ||
               ((mode == OP_MMUL) && (nops == 3'd4));
    endfunction

endpackage

// File: rtl/ecc_opd_buf.sv
// Four-entry operand buffer: words are written in arrival order and read back in the same order.
// Pointers restart on rst or clr; stored words are simply overwritten by the next command.
module ecc_opd_buf #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic [1:0]       wr_ptr
);

    logic [WIDTH-1:0] mem [4];
    logic [1:0]       rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 2'd1;
            if (rd_en) rd_ptr <= rd_ptr + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_dat;
    end

    assign rd_dat = mem[rd_ptr];

endmodule

// File: rtl/ecc_op_sequencer.sv
// ECC operation sequencer: accepts a command, gathers operands, bursts them to the engine
// decoder, waits for completion with a timeout, and returns a one-cycle response.
module ecc_op_sequencer
    import ecc_pkg::*;
#(
    parameter int WIDTH   = 256,
    parameter int TMO_CYC = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_vld,
    output logic             cmd_rdy,
    input  logic [2:0]       cmd_mode,
    input  logic [2:0]       cmd_nops,
    input  logic             opd_vld,
    output logic             opd_rdy,
    input  logic [WIDTH-1:0] opd_dat,
    output logic             auc_start,
    output logic [2:0]       auc_mode,
    output logic [WIDTH-1:0] auc_dat,
    input  logic             eng_done,
    output logic             rsp_vld,
    output logic [1:0]       rsp_err,
    output logic             busy
);

    state_t           state, nxt;
    logic [2:0]       nops_q;
    logic [2:0]       iss_cnt;
    logic [2:0]       burst_len;
    logic [15:0]      tmo_cnt;
    logic [1:0]       err_d;
    logic             cmd_acc, opd_acc;
    logic [1:0]       buf_wr_ptr;
    logic [WIDTH-1:0] buf_dat;
    logic             buf_rd;

    logic             cmd_rdy_d, opd_rdy_d, auc_start_d, rsp_vld_d, busy_d;
    logic [WIDTH-1:0] auc_dat_d;
    logic [1:0]       rsp_err_d;

    assign cmd_acc   = cmd_vld && cmd_rdy;
    assign opd_acc   = opd_vld && opd_rdy;
    assign burst_len = (nops_q == 3'd0) ? 3'd1 : nops_q;

    ecc_opd_buf #(.WIDTH(WIDTH)) u_opd_buf (
        .clk    (clk),
        .rst    (rst),
        .clr    (cmd_acc),
        .wr_en  (opd_acc),
        .wr_dat (opd_dat),
        .rd_en  (buf_rd),
        .rd_dat (buf_dat),
        .wr_ptr (buf_wr_ptr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            nops_q  <= 3'd0;
            iss_cnt <= 3'd0;
            tmo_cnt <= 16'd0;
        end else begin
            state   <= nxt;
            if (cmd_acc) nops_q <= cmd_nops;
            iss_cnt <= (state == ST_ISSUE) ? iss_cnt + 3'd1 : 3'd0;
            if (state == ST_GAP)
                tmo_cnt <= 16'(TMO_CYC);
            else if ((state == ST_WAIT) && (tmo_cnt != 16'd0))
                tmo_cnt <= tmo_cnt - 16'd1;
        end
    end

    always_comb begin
        nxt   = state;
        err_d = ERR_OK;
        case (state)
            ST_IDLE: begin
                if (cmd_acc) begin
                    if (!cmd_legal(cmd_mode, cmd_nops)) begin
                        nxt   = ST_RESP;
                        err_d = ERR_ILLEGAL;
                    end else if (cmd_nops == 3'd0) begin
                        nxt = ST_ISSUE;
                    end else begin
                        nxt = ST_LOAD;
                    end
                end
            end
            ST_LOAD:  if (opd_acc && (buf_wr_ptr == 2'd3)) nxt = ST_ISSUE;
            ST_ISSUE: if (iss_cnt == burst_len - 3'd1) nxt = ST_GAP;
            ST_GAP:   nxt = ST_WAIT;
            ST_WAIT: begin
                // Completion takes priority over a simultaneous expiry.
                if (eng_done) begin
                    nxt   = ST_RESP;
                    err_d = ERR_OK;
                end else if (tmo_cnt == 16'd0) begin
                    nxt   = ST_RESP;
                    err_d = ERR_TIMEOUT;
                end
            end
            ST_RESP:  nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight from a flop.
    always_comb begin
        cmd_rdy_d   = (nxt == ST_IDLE);
        opd_rdy_d   = (nxt == ST_LOAD);
        auc_start_d = (nxt == ST_ISSUE);
        buf_rd      = auc_start_d && (state != ST_IDLE) && (nops_q != 3'd0);
        auc_dat_d   = buf_rd ? buf_dat : '0;
        rsp_vld_d   = (nxt == ST_RESP);
        rsp_err_d   = rsp_vld_d ? err_d : ERR_OK;
        busy_d      = (nxt != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_rdy   <= 1'b0;
            opd_rdy   <= 1'b0;
            auc_start <= 1'b0;
            auc_mode  <= 3'b000;
            auc_dat   <= '0;
            rsp_vld   <= 1'b0;
            rsp_err   <= ERR_OK;
            busy      <= 1'b0;
        end else begin
            cmd_rdy   <= cmd_rdy_d;
            opd_rdy   <= opd_rdy_d;
            auc_start <= auc_start_d;
            if (cmd_acc) auc_mode <= cmd_mode;
            auc_dat   <= auc_dat_d;
            rsp_vld   <= rsp_vld_d;
            rsp_err   <= rsp_err_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_ecc_op_sequencer.sv
// Directed bench for ecc_op_sequencer: one default-timeout instance and one with an
// eight-cycle timeout share all inputs so the timeout cases can be observed directly.
module tb_ecc_op_sequencer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_vld;
    logic [2:0]   cmd_mode;
    logic [2:0]   cmd_nops;
    logic         opd_vld;
    logic [W-1:0] opd_dat;
    logic         eng_done;

    logic         cmd_rdy, opd_rdy, auc_start, rsp_vld, busy;
    logic [2:0]   auc_mode;
    logic [W-1:0] auc_dat;
    logic [1:0]   rsp_err;

    logic         cmd_rdy_t, opd_rdy_t, auc_start_t, rsp_vld_t, busy_t;
    logic [2:0]   auc_mode_t;
    logic [W-1:0] auc_dat_t;
    logic [1:0]   rsp_err_t;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ecc_op_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_mode(cmd_mode), .cmd_nops(cmd_nops),
        .opd_vld(opd_vld), .opd_rdy(opd_rdy), .opd_dat(opd_dat),
        .auc_start(auc_start), .auc_mode(auc_mode), .auc_dat(auc_dat),
        .eng_done(eng_done),
        .rsp_vld(rsp_vld), .rsp_err(rsp_err), .busy(busy)
    );

    ecc_op_sequencer #(.WIDTH(W), .TMO_CYC(8)) dut_t (
        .clk(clk), .rst(rst),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy_t), .cmd_mode(cmd_mode), .cmd_nops(cmd_nops),
        .opd_vld(opd_vld), .opd_rdy(opd_rdy_t), .opd_dat(opd_dat),
        .auc_start(auc_start_t), .auc_mode(auc_mode_t), .auc_dat(auc_dat_t),
        .eng_done(eng_done),
        .rsp_vld(rsp_vld_t), .rsp_err(rsp_err_t), .busy(busy_t)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [2:0] mode, input logic [2:0] nops);
        cmd_vld  = 1'b1;
        cmd_mode = mode;
        cmd_nops = nops;
        step();
        cmd_vld  = 1'b0;
    endtask

    // Full MMUL command up to and including the GAP cycle.
    task automatic mmul_op(input logic [W-1:0] w0, input logic [W-1:0] w1,
                           input logic [W-1:0] w2, input logic [W-1:0] w3,
                           input logic done_in_load);
        logic [W-1:0] wv [4];
        wv[0] = w0; wv[1] = w1; wv[2] = w2; wv[3] = w3;
        send_cmd(3'b101, 3'd4);
        chk("load_opd_rdy", 32'(opd_rdy), 1);
        chk("load_cmd_rdy", 32'(cmd_rdy), 0);
        chk("load_busy", 32'(busy), 1);
        opd_vld  = 1'b1;
        eng_done = done_in_load;
        for (int i = 0; i < 4; i++) begin
            opd_dat = wv[i];
            step();
            eng_done = 1'b0;
            if (i < 3) chk("load_opd_rdy_hold", 32'(opd_rdy), 1);
        end
        opd_vld = 1'b0;
        chk("issue_opd_rdy", 32'(opd_rdy), 0);
        for (int i = 0; i < 4; i++) begin
            chk("issue_start", 32'(auc_start), 1);
            chk("issue_dat", 32'(auc_dat), 32'(wv[i]));
            chk("issue_mode", 32'(auc_mode), 32'h5);
            step();
        end
        chk("gap_start", 32'(auc_start), 0);
        chk("gap_dat", 32'(auc_dat), 0);
        chk("gap_mode", 32'(auc_mode), 32'h5);
        chk("gap_busy", 32'(busy), 1);
    endtask

    initial begin
        rst = 1'b1; cmd_vld = 1'b0; cmd_mode = 3'd0; cmd_nops = 3'd0;
        opd_vld = 1'b0; opd_dat = '0; eng_done = 1'b0;
        step();
        step();
        chk("rst_cmd_rdy", 32'(cmd_rdy), 0);
        chk("rst_opd_rdy", 32'(opd_rdy), 0);
        chk("rst_start", 32'(auc_start), 0);
        chk("rst_mode", 32'(auc_mode), 0);
        chk("rst_dat", 32'(auc_dat), 0);
        chk("rst_rsp_vld", 32'(rsp_vld), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        step();
        chk("idle_cmd_rdy", 32'(cmd_rdy), 1);
        chk("idle_busy", 32'(busy), 0);

        // MMUL with eng_done during LOAD; the 8-cycle instance times out meanwhile.
        mmul_op(16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3, 1'b1);
        step();
        chk("w0_rsp_vld", 32'(rsp_vld), 0);
        chk("w0_rsp_vld_t", 32'(rsp_vld_t), 0);
        for (int i = 1; i <= 20; i++) begin
            eng_done = (i == 20);
            step();
            chk("tmo_rsp_vld_t", 32'(rsp_vld_t), 32'(i == 9));
            if (i == 9) chk("tmo_rsp_err_t", 32'(rsp_err_t), 32'h2);
            chk("mmul_rsp_vld", 32'(rsp_vld), 32'(i == 20));
            if (i == 20) chk("mmul_rsp_err", 32'(rsp_err), 0);
        end
        eng_done = 1'b0;
        step();
        chk("mmul_post_rsp_vld", 32'(rsp_vld), 0);
        chk("mmul_post_cmd_rdy", 32'(cmd_rdy), 1);
        chk("mmul_post_busy", 32'(busy), 0);

        // RAND, no operands: one start cycle carrying zero.
        opd_vld = 1'b1;
        opd_dat = 16'h5555;
        send_cmd(3'b000, 3'd0);
        chk("rand_start", 32'(auc_start), 1);
        chk("rand_dat", 32'(auc_dat), 0);
        chk("rand_mode", 32'(auc_mode), 0);
        chk("rand_opd_rdy", 32'(opd_rdy), 0);
        step();
        chk("rand_gap_start", 32'(auc_start), 0);
        chk("rand_gap_opd_rdy", 32'(opd_rdy), 0);
        opd_vld = 1'b0;
        step();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        chk("rand_rsp_vld", 32'(rsp_vld), 1);
        chk("rand_rsp_err", 32'(rsp_err), 0);
        chk("rand_rsp_vld_t", 32'(rsp_vld_t), 1);
        step();
        chk("rand_post_cmd_rdy", 32'(cmd_rdy), 1);

        // Illegal: undefined mode, then MMUL with the wrong operand count.
        send_cmd(3'b011, 3'd0);
        chk("ill_mode_rsp_vld", 32'(rsp_vld), 1);
        chk("ill_mode_rsp_err", 32'(rsp_err), 1);
        chk("ill_mode_start", 32'(auc_start), 0);
        step();
        chk("ill_mode_post_vld", 32'(rsp_vld), 0);
        chk("ill_mode_post_rdy", 32'(cmd_rdy), 1);
        chk("ill_mode_post_start", 32'(auc_start), 0);
        send_cmd(3'b101, 3'd2);
        chk("ill_nops_rsp_vld", 32'(rsp_vld), 1);
        chk("ill_nops_rsp_err", 32'(rsp_err), 1);
        chk("ill_nops_start", 32'(auc_start), 0);
        chk("ill_nops_opd_rdy", 32'(opd_rdy), 0);
        step();
        chk("ill_nops_post_vld", 32'(rsp_vld), 0);
        chk("ill_nops_post_rdy", 32'(cmd_rdy), 1);

        // INVS with eng_done landing exactly on the 8-cycle expiry.
        send_cmd(3'b001, 3'd0);
        chk("invs_start", 32'(auc_start), 1);
        chk("invs_mode", 32'(auc_mode), 1);
        step();
        step();
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("coinc_wait_vld_t", 32'(rsp_vld_t), 0);
        end
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        chk("coinc_rsp_vld_t", 32'(rsp_vld_t), 1);
        chk("coinc_rsp_err_t", 32'(rsp_err_t), 0);
        chk("coinc_rsp_vld", 32'(rsp_vld), 1);
        step();
        chk("coinc_post_rdy", 32'(cmd_rdy), 1);

        // Reset during the second ISSUE cycle aborts silently.
        send_cmd(3'b101, 3'd4);
        opd_vld = 1'b1;
        opd_dat = 16'h1E1E; step();
        opd_dat = 16'h2F2F; step();
        opd_dat = 16'h3A3A; step();
        opd_dat = 16'h4B4B; step();
        opd_vld = 1'b0;
        chk("abort_issue1_dat", 32'(auc_dat), 32'h1E1E);
        step();
        chk("abort_issue2_dat", 32'(auc_dat), 32'h2F2F);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_start", 32'(auc_start), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_rsp_vld", 32'(rsp_vld), 0);
        chk("abort_dat", 32'(auc_dat), 0);
        chk("abort_cmd_rdy", 32'(cmd_rdy), 0);
        step();
        chk("abort_post_rdy", 32'(cmd_rdy), 1);
        chk("abort_post_vld", 32'(rsp_vld), 0);

        // Fresh MMUL after the abort must start from buffer entry 0.
        mmul_op(16'h0101, 16'h0202, 16'h0303, 16'h0404, 1'b0);
        step();
        step();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        chk("resume_rsp_vld", 32'(rsp_vld), 1);
        chk("resume_rsp_err", 32'(rsp_err), 0);
        step();
        chk("resume_post_vld", 32'(rsp_vld), 0);
        chk("resume_post_rdy", 32'(cmd_rdy), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
